// File: rtl/shared_mac_scheduler.sv
// shared_mac_scheduler: round-robin altitude/battery MAC over one multiplier.
// Optional self test is compiled in with `define BIST_EN.
module shared_mac_scheduler #(
    parameter int          DW          = 8,
    parameter int          K1          = 3,
    parameter int          K2          = 5,
    parameter int          BIST_OPS    = 16,
    parameter logic [15:0] BIST_GOLDEN = 16'h0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 alt_req,
    input  logic signed [DW-1:0] alt_x1,
    input  logic signed [DW-1:0] alt_x2,
    output logic                 alt_ack,
    input  logic                 batt_req,
    input  logic signed [DW-1:0] batt_v,
    input  logic signed [DW-1:0] batt_t,
    input  logic signed [DW-1:0] batt_c,
    output logic                 batt_ack,
    output logic signed [2*DW:0] out,
    output logic                 op_valid,
    output logic                 op_type,
    output logic                 busy
`ifdef BIST_EN
    ,
    input  logic                 bist_start,
    output logic                 bist_done,
    output logic                 bist_pass
`endif
);

    localparam int OW = 2*DW+1;
    localparam logic signed [DW-1:0] K1_C = DW'(K1);
    localparam logic signed [DW-1:0] K2_C = DW'(K2);

`ifdef BIST_EN
    typedef enum logic [2:0] {IDLE, ALT1, ALT2, BATT, BIST} state_e;
`else
    typedef enum logic [1:0] {IDLE, ALT1, ALT2, BATT} state_e;
`endif

    state_e state_q, state_d;
    logic last_q, last_d;
    logic signed [DW-1:0] x1_q, x1_d, x2_q, x2_d;
    logic signed [DW-1:0] v_q, v_d, t_q, t_d, c_q, c_d;
    logic signed [OW-1:0] acc_q, acc_d, out_q, out_d;
    logic valid_q, valid_d, type_q, type_d;
    logic aack_q, aack_d, back_q, back_d;

    logic signed [DW-1:0]   mul_a, mul_b;
    logic signed [2*DW-1:0] prod;
    logic signed [OW-1:0]   add_b, sum;
    logic grant_alt, grant_batt;

    // Altitude wins when alone or when battery was served last.
    assign grant_alt  = alt_req && (!batt_req || last_q);
    assign grant_batt = batt_req && !grant_alt;

`ifdef BIST_EN
    logic [15:0] lfsr_q, lfsr_d, misr_q, misr_d;
    logic [15:0] s1, s2, s3, misr_nx;
    logic [15:0] bcnt_q, bcnt_d;
    logic bmode_q, bmode_d, balt_q, balt_d;
    logic done_q, done_d, pass_q, pass_d;
    localparam logic [15:0] OPS_C = 16'(BIST_OPS);
    localparam logic [15:0] SEED  = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    assign s1 = lfsr_step(lfsr_q);
    assign s2 = lfsr_step(s1);
    assign s3 = lfsr_step(s2);
    assign misr_nx = lfsr_step(misr_q) ^ 16'(sum);
    assign bist_done = done_q;
    assign bist_pass = pass_q;
`endif

    // Operand mux feeding the single shared multiplier and adder.
    always_comb begin
        mul_a = x1_q;
        mul_b = K1_C;
        add_b = '0;
        case (state_q)
            ALT1: begin
                mul_a = x1_q;
                mul_b = K1_C;
            end
            ALT2: begin
                mul_a = x2_q;
                mul_b = K2_C;
                add_b = acc_q;
            end
            BATT: begin
                mul_a = v_q;
                mul_b = t_q;
                add_b = OW'(c_q);
            end
            default: ;
        endcase
        prod = mul_a * mul_b;
        sum  = OW'(prod) + add_b;
    end

    // Next-state, arbitration and result capture.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        v_d     = v_q;
        t_d     = t_q;
        c_d     = c_q;
        acc_d   = acc_q;
        out_d   = out_q;
        type_d  = type_q;
        valid_d = 1'b0;
        aack_d  = 1'b0;
        back_d  = 1'b0;
`ifdef BIST_EN
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        bcnt_d  = bcnt_q;
        bmode_d = bmode_q;
        balt_d  = balt_q;
        done_d  = done_q;
        pass_d  = pass_q;
`endif
        if (enable) begin
            case (state_q)
                IDLE: begin
`ifdef BIST_EN
                    if (bist_start) begin
                        lfsr_d  = SEED;
                        misr_d  = '0;
                        bcnt_d  = '0;
                        bmode_d = 1'b1;
                        balt_d  = 1'b1;
                        done_d  = 1'b0;
                        pass_d  = 1'b0;
                        state_d = BIST;
                    end else
`endif
                    if (grant_alt) begin
                        aack_d  = 1'b1;
                        x1_d    = alt_x1;
                        x2_d    = alt_x2;
                        last_d  = 1'b0;
                        state_d = ALT1;
                    end else if (grant_batt) begin
                        back_d  = 1'b1;
                        v_d     = batt_v;
                        t_d     = batt_t;
                        c_d     = batt_c;
                        last_d  = 1'b1;
                        state_d = BATT;
                    end
                end
                ALT1: begin
                    acc_d   = sum;
                    state_d = ALT2;
                end
                ALT2: begin
                    state_d = IDLE;
`ifdef BIST_EN
                    if (bmode_q) begin
                        misr_d  = misr_nx;
                        bcnt_d  = bcnt_q + 16'd1;
                        state_d = BIST;
                    end else
`endif
                    begin
                        out_d   = sum;
                        valid_d = 1'b1;
                        type_d  = 1'b0;
                    end
                end
                BATT: begin
                    state_d = IDLE;
`ifdef BIST_EN
                    if (bmode_q) begin
                        misr_d  = misr_nx;
                        bcnt_d  = bcnt_q + 16'd1;
                        state_d = BIST;
                    end else
`endif
                    begin
                        out_d   = sum;
                        valid_d = 1'b1;
                        type_d  = 1'b1;
                    end
                end
`ifdef BIST_EN
                BIST: begin
                    if (bcnt_q == OPS_C) begin
                        done_d  = 1'b1;
                        pass_d  = (misr_q == BIST_GOLDEN);
                        bmode_d = 1'b0;
                        state_d = IDLE;
                    end else if (balt_q) begin
                        x1_d    = lfsr_q[DW-1:0];
                        x2_d    = s1[DW-1:0];
                        lfsr_d  = s2;
                        balt_d  = 1'b0;
                        state_d = ALT1;
                    end else begin
                        v_d     = lfsr_q[DW-1:0];
                        t_d     = s1[DW-1:0];
                        c_d     = s2[DW-1:0];
                        lfsr_d  = s3;
                        balt_d  = 1'b1;
                        state_d = BATT;
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            x1_q    <= '0;
            x2_q    <= '0;
            v_q     <= '0;
            t_q     <= '0;
            c_q     <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            type_q  <= 1'b0;
            aack_q  <= 1'b0;
            back_q  <= 1'b0;
`ifdef BIST_EN
            lfsr_q  <= SEED;
            misr_q  <= '0;
            bcnt_q  <= '0;
            bmode_q <= 1'b0;
            balt_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            v_q     <= v_d;
            t_q     <= t_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            type_q  <= type_d;
            aack_q  <= aack_d;
            back_q  <= back_d;
`ifdef BIST_EN
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            bcnt_q  <= bcnt_d;
            bmode_q <= bmode_d;
            balt_q  <= balt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`endif
        end
    end

    assign out      = out_q;
    assign op_valid = valid_q;
    assign op_type  = type_q;
    assign alt_ack  = aack_q;
    assign batt_ack = back_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shared_mac_scheduler.sv
// tb_shared_mac_scheduler: directed checks of arbitration, latency and results.
// Self-test section is compiled only with `define BIST_EN.
`timescale 1ns/1ps
module tb_shared_mac_scheduler;

    logic clk = 1'b0;
    logic reset, enable, alt_req, batt_req;
    logic signed [7:0] alt_x1, alt_x2, batt_v, batt_t, batt_c;
    logic alt_ack, batt_ack, op_valid, op_type, busy;
    logic signed [16:0] out;
    int checks = 0;
    int errors = 0;
    logic [9:0] e_aa, e_ba, e_v;

`ifdef BIST_EN
    logic bist_start, bist_done, bist_pass;
    logic bad_done, bad_pass;
    logic bad_aack, bad_back, bad_valid, bad_type, bad_busy;
    logic signed [16:0] bad_out;
    logic acked;

    function automatic logic [15:0] bist_model(input int ops);
        logic [15:0] l, m;
        logic signed [7:0] a, b, c;
        logic signed [16:0] r;
        logic alt;
        l = 16'hACE1;
        m = 16'h0000;
        alt = 1'b1;
        for (int k = 0; k < ops; k++) begin
            a = l[7:0];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            b = l[7:0];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            if (alt) begin
                r = a * 8'sd3 + b * 8'sd5;
            end else begin
                c = l[7:0];
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
                r = a * b + c;
            end
            m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ r[15:0];
            alt = !alt;
        end
        return m;
    endfunction
`endif

    always #5 clk = ~clk;

    shared_mac_scheduler #(
        .DW(8), .K1(3), .K2(5)
`ifdef BIST_EN
        , .BIST_OPS(16), .BIST_GOLDEN(bist_model(16))
`endif
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .alt_req(alt_req), .alt_x1(alt_x1), .alt_x2(alt_x2),
        .alt_ack(alt_ack),
        .batt_req(batt_req), .batt_v(batt_v), .batt_t(batt_t),
        .batt_c(batt_c), .batt_ack(batt_ack),
        .out(out), .op_valid(op_valid), .op_type(op_type),
        .busy(busy)
`ifdef BIST_EN
        , .bist_start(bist_start), .bist_done(bist_done),
        .bist_pass(bist_pass)
`endif
    );

`ifdef BIST_EN
    shared_mac_scheduler #(
        .DW(8), .K1(3), .K2(5),
        .BIST_OPS(16), .BIST_GOLDEN(~bist_model(16))
    ) bad (
        .clk(clk), .reset(reset), .enable(enable),
        .alt_req(alt_req), .alt_x1(alt_x1), .alt_x2(alt_x2),
        .alt_ack(bad_aack),
        .batt_req(batt_req), .batt_v(batt_v), .batt_t(batt_t),
        .batt_c(batt_c), .batt_ack(bad_back),
        .out(bad_out), .op_valid(bad_valid), .op_type(bad_type),
        .busy(bad_busy),
        .bist_start(bist_start), .bist_done(bad_done),
        .bist_pass(bad_pass)
    );
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        alt_req = 1'b0; batt_req = 1'b0;
        alt_x1 = '0; alt_x2 = '0;
        batt_v = '0; batt_t = '0; batt_c = '0;
`ifdef BIST_EN
        bist_start = 1'b0;
`endif
        tick();
        tick();
        check("rst_out", out, 0);
        check("rst_valid", op_valid, 0);
        check("rst_type", op_type, 0);
        check("rst_busy", busy, 0);
        check("rst_aack", alt_ack, 0);
        check("rst_back", batt_ack, 0);
        reset = 1'b0;

        // altitude 10*3 + -4*5 = 10, two cycles after ack
        alt_req = 1'b1; alt_x1 = 8'sd10; alt_x2 = -8'sd4;
        tick();
        check("alt_ack", alt_ack, 1);
        check("alt_busy", busy, 1);
        alt_req = 1'b0;
        tick();
        check("alt_ack_pulse", alt_ack, 0);
        check("alt_valid_early", op_valid, 0);
        tick();
        check("alt_valid", op_valid, 1);
        check("alt_out", out, 10);
        check("alt_type", op_type, 0);
        tick();
        check("alt_valid_pulse", op_valid, 0);
        check("alt_out_hold", out, 10);
        check("alt_idle", busy, 0);

        // battery extremes
        batt_req = 1'b1; batt_v = -8'sd128; batt_t = -8'sd128;
        batt_c = 8'sd127;
        tick();
        check("batt_ack", batt_ack, 1);
        batt_req = 1'b0;
        tick();
        check("batt_valid", op_valid, 1);
        check("batt_out_pos", out, 16511);
        check("batt_type", op_type, 1);
        batt_req = 1'b1; batt_v = 8'sd127; batt_t = -8'sd128;
        batt_c = -8'sd128;
        tick();
        check("batt2_ack", batt_ack, 1);
        batt_req = 1'b0;
        tick();
        check("batt_out_neg", out, -16384);

        // both held after reset: alt, batt, alt, batt
        reset = 1'b1;
        tick();
        reset = 1'b0;
        alt_req = 1'b1; alt_x1 = 8'sd1; alt_x2 = 8'sd2;
        batt_req = 1'b1; batt_v = 8'sd3; batt_t = 8'sd4; batt_c = 8'sd5;
        e_aa = 10'b0000100001;
        e_ba = 10'b0100001000;
        e_v  = 10'b1010010100;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rr_aack", alt_ack, e_aa[i]);
            check("rr_back", batt_ack, e_ba[i]);
            check("rr_valid", op_valid, e_v[i]);
            if (e_v[i]) begin
                if (i == 2 || i == 7) begin
                    check("rr_alt_out", out, 13);
                    check("rr_alt_type", op_type, 0);
                end else begin
                    check("rr_batt_out", out, 17);
                    check("rr_batt_type", op_type, 1);
                end
            end
        end
        alt_req = 1'b0; batt_req = 1'b0;
        tick();

        // enable low for 4 cycles in ALT1: -7*3 + 6*5 = 9
        alt_req = 1'b1; alt_x1 = -8'sd7; alt_x2 = 8'sd6;
        tick();
        check("en_ack", alt_ack, 1);
        alt_req = 1'b0; enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("en_hold_valid", op_valid, 0);
            check("en_hold_busy", busy, 1);
            check("en_hold_ack", alt_ack, 0);
        end
        enable = 1'b1;
        tick();
        check("en_resume_mid", op_valid, 0);
        tick();
        check("en_resume_valid", op_valid, 1);
        check("en_resume_out", out, 9);
        tick();

        // reset during ALT2 aborts the operation
        alt_req = 1'b1; alt_x1 = 8'sd2; alt_x2 = 8'sd2;
        tick();
        check("abort_ack", alt_ack, 1);
        alt_req = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("abort_valid", op_valid, 0);
        check("abort_out", out, 0);
        check("abort_busy", busy, 0);
        reset = 1'b0;
        batt_req = 1'b1; batt_v = 8'sd2; batt_t = 8'sd3; batt_c = -8'sd1;
        tick();
        check("post_abort_ack", batt_ack, 1);
        batt_req = 1'b0;
        tick();
        check("post_abort_out", out, 5);
        check("post_abort_valid", op_valid, 1);

        // request dropped before any ack is not served
        enable = 1'b0; alt_req = 1'b1;
        tick();
        check("drop_ack_dis", alt_ack, 0);
        alt_req = 1'b0; enable = 1'b1;
        tick();
        check("drop_ack", alt_ack, 0);
        check("drop_busy", busy, 0);

`ifdef BIST_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bist_start = 1'b1;
        alt_req = 1'b1; alt_x1 = 8'sd1; alt_x2 = 8'sd1;
        tick();
        bist_start = 1'b0;
        check("bist_busy", busy, 1);
        check("bist_prio", alt_ack, 0);
        acked = 1'b0;
        for (int n = 0; n < 400 && !bist_done; n++) begin
            tick();
            if (alt_ack || op_valid) acked = 1'b1;
        end
        check("bist_done", bist_done, 1);
        check("bist_no_ack", acked, 0);
        check("bist_pass", bist_pass, 1);
        check("bist_bad_done", bad_done, 1);
        check("bist_bad_pass", bad_pass, 0);
        tick();
        check("bist_then_ack", alt_ack, 1);
        check("bist_sticky", bist_done, 1);
        alt_req = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shared_mac_scheduler.md
Name: shared_mac_scheduler

Overview:
Parametrised successor to the team's time-multiplexed altitude/battery controller. Serves two request channels with one signed multiplier and one adder:
- Altitude: x1*K1 + x2*K2.
- Battery: v*t + c.

Adds per-channel req/ack handshakes, round-robin arbitration, configurable width and coefficients, and an optional built-in self test. It sits between the sensor front-ends and the telemetry packer.

Parameters:
DW, 8, signed operand width (valid range 4..16)
K1, 3, signed DW-bit altitude coefficient for x1
K2, 5, signed DW-bit altitude coefficient for x2
BIST_OPS, 16, number of operations run in one self test (BIST_EN only)
BIST_GOLDEN, 16'h0000, expected MISR signature (BIST_EN only)
(derived, not a parameter) OW = 2*DW+1, result width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous active-high reset
enable  in  1  clock enable; low freezes FSM and accumulator
alt_req  in  1  altitude request, level; held until alt_ack
alt_x1  in  DW  signed altitude operand 1
alt_x2  in  DW  signed altitude operand 2
alt_ack  out  1  one-cycle pulse; operands captured this cycle
batt_req  in  1  battery request, level; held until batt_ack
batt_v  in  DW  signed voltage operand
batt_t  in  DW  signed temperature operand
batt_c  in  DW  signed offset operand
batt_ack  out  1  one-cycle pulse; operands captured this cycle
out  out  OW  signed result
op_valid  out  1  one-cycle pulse; out is valid
op_type  out  1  0 = altitude, 1 = battery; qualified by op_valid
busy  out  1  high whenever state != IDLE
bist_start  in  1  start self test (BIST_EN only)
bist_done  out  1  sticky; test finished (BIST_EN only)
bist_pass  out  1  signature matched; valid when bist_done (BIST_EN only)

Behaviour:
- Reset, synchronous and active-high, applies on the clock edge:
  - state = IDLE, last_served = 1 (battery), so altitude wins the first tie.
  - Outputs: out = 0, op_valid = 0, op_type = 0, alt_ack = 0, batt_ack = 0, busy = 0.
  - Internal: acc = 0.
  - Reset mid-operation aborts it: no op_valid, captured operands discarded.
- States: IDLE, ALT1, ALT2, BATT (plus BIST under BIST_EN).
- IDLE with enable = 1:
  - Only one request asserted: grant it.
  - Both asserted: grant the channel opposite last_served.
  - A grant pulses the matching ack for one cycle, registers the operands and updates last_served.
  - Next state: ALT1 or BATT. No request: stay in IDLE.
- ALT1: acc <= x1*K1 (full 2*DW product, sign-extended to OW); next state ALT2.
- ALT2: out <= acc + x2*K2; op_valid <= 1; op_type <= 0; next state IDLE.
- BATT: out <= v*t + c, with c sign-extended; op_valid <= 1; op_type <= 1; next state IDLE.
- Latency from the ack edge to op_valid high:
  - Altitude: 2 cycles.
  - Battery: 1 cycle.
- Throughput: altitude every 3 cycles, battery every 2 cycles; ack cannot occur in the cycle op_valid is high.
- Exactly one multiplier instance, shared across ALT1, ALT2 and BATT through an operand mux.
- Arithmetic is signed two's complement. OW bits cannot overflow for any operand or coefficient values.
- op_valid is low in every cycle not following ALT2 or BATT.
- out holds its last value until the next result.
- enable = 0:
  - FSM, acc and out hold.
  - op_valid and both acks are forced to 0.
  - An operation interrupted by enable low resumes where it stopped when enable returns.
- A request dropped before its ack is simply not served. A request held after its ack is served again; this is legal back-to-back use.

Optional Feature:
BIST_EN:
- When defined, the bist_* ports and the BIST state exist.
- bist_start is sampled in IDLE (with enable). It has priority over both requests and clears bist_done.
- The test runs BIST_OPS operations through the same datapath, alternating altitude and battery, starting with altitude.
- Operands are the low DW bits of a 16-bit Fibonacci LFSR:
  - seed 16'hACE1, taps x^16+x^14+x^13+x^11+1.
  - One LFSR step per operand, in order x1, x2 / v, t, c.
- Each result is compacted as MISR <= {MISR[14:0], MISR[15]^MISR[13]^MISR[12]^MISR[10]} ^ out[15:0]; MISR seed is 0.
- When the test ends:
  - bist_done = 1 (sticky).
  - bist_pass = (MISR == BIST_GOLDEN).
  - The FSM returns to IDLE.
- During the test:
  - op_valid stays 0 and no ack is issued.
  - busy = 1.
- Reset clears the LFSR, MISR, bist_done and bist_pass.
- Without BIST_EN: the ports are absent and no LFSR/MISR logic is synthesised.

Test Plan:
- DW=8, K1=3, K2=5; alt_req with x1=10, x2=-4 -> alt_ack at cycle 0, op_valid at cycle 2, out=10, op_type=0.
- batt_req with v=-128, t=-128, c=127 -> batt_ack at cycle 0, op_valid at cycle 1, out=16511, op_type=1; v=127, t=-128, c=-128 -> out=-16384.
- Both requests held continuously after reset -> ack order alt, batt, alt, batt; results alternate; valid pulses at a 5-cycle period per pair.
- Altitude accepted, then enable low for 4 cycles during ALT1 -> no op_valid while low; correct result 2 enabled cycles after the ack.
- Reset asserted in ALT2 -> no op_valid; out=0 and busy=0 next cycle; a new request is acked normally.
- BIST_EN defined, BIST_OPS=16, BIST_GOLDEN from the bench model -> bist_done after the run, bist_pass=1. Wrong golden value -> bist_pass=0. Requests issued during the test are not acked until it completes.
